// File: rtl/dsw_ser_if.sv
// DIP-switch serial link pins between the polling reader (master) and the switch register (slave).
// Latency: none, plain wires.
// Backpressure: none; the reader paces the link with dsw_sht/dsw_clk.
interface dsw_ser_if;
   logic dsw_sht;   // low = load, high = shift
   logic dsw_clk;   // rising edge advances one bit
   logic dsw_dat;   // serial data, low = switch ON

   modport master (output dsw_sht, output dsw_clk, input dsw_dat);
   modport slave  (input dsw_sht, input dsw_clk, output dsw_dat);
endinterface

// File: rtl/dsw_ser.sv
// Emulates the 8-bit PISO DIP-switch register: debounce, load on dsw_sht low, MSB-first shift on dsw_clk.
// Latency: dsw_dat follows a load/shift pin edge by SYNC_STAGES+2 clk; sw_on lags a stable change by SYNC_STAGES+DEB_CYCLES.
// Backpressure: none; the reader paces every bit, shifts past bit 8 emit OFF (1), load always wins over a shift.
module dsw_ser #(
   parameter int SYNC_STAGES    = 2,
   parameter int DEB_CYCLES     = 250000,
   parameter int TIMEOUT_CYCLES = 524288
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sw_n,
   dsw_ser_if.slave   dsw,
   output logic [7:0] sw_on,
   output logic       frame_tp,
   output logic [3:0] bit_cnt,
   output logic       link_ok
);

   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   // synchronizer chains, last stage at the top index
   logic [SYNC_STAGES-1:0]      sht_sync_q, sht_sync_d;
   logic [SYNC_STAGES-1:0]      clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0][7:0] sw_sync_q, sw_sync_d;
   logic                        clk_hist_q, clk_hist_d;

   // debounce state
   logic [7:0][DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
   logic [7:0]                  sw_on_q, sw_on_d;

   // frame / link state; shreg holds line levels (1 = OFF) so reset and fill both idle the line high
   logic [7:0]                  shreg_q, shreg_d;
   logic                        dsw_dat_q, dsw_dat_d;
   logic [3:0]                  bit_cnt_q, bit_cnt_d;
   logic                        frame_tp_q, frame_tp_d;
   logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
   logic                        link_ok_q, link_ok_d;

   logic                        sht_s, clk_s, load, shift_evt;
   logic [7:0]                  sw_smp;

   assign sht_s     = sht_sync_q[SYNC_STAGES-1];
   assign clk_s     = clk_sync_q[SYNC_STAGES-1];
   assign sw_smp    = sw_sync_q[SYNC_STAGES-1];
   assign load      = ~sht_s;
   assign shift_evt = sht_s & clk_s & ~clk_hist_q;

   // advance every synchronizer chain by one stage and remember the previous clk sample
   always_comb begin
      sht_sync_d   = {sht_sync_q[SYNC_STAGES-2:0], dsw.dsw_sht};
      clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], dsw.dsw_clk};
      sw_sync_d    = sw_sync_q;
      sw_sync_d[0] = sw_n;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sw_sync_d[k] = sw_sync_q[k-1];
      end
      clk_hist_d   = clk_s;
   end

   // per-switch debounce: accept a new level only after DEB_CYCLES consecutive disagreeing samples
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      sw_on_d   = sw_on_q;
      for (int i = 0; i < 8; i++) begin
         if (~sw_smp[i] == sw_on_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
            sw_on_d[i]   = ~sw_smp[i];
            deb_cnt_d[i] = '0;
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
         end
      end
   end

   // load/shift the frame register, count bits, flag frame end, and watch for the reader's poll
   always_comb begin
      shreg_d    = shreg_q;
      dsw_dat_d  = shreg_q[7];
      bit_cnt_d  = bit_cnt_q;
      frame_tp_d = 1'b0;
      to_cnt_d   = to_cnt_q;
      link_ok_d  = link_ok_q;
      if (load) begin
         shreg_d   = ~sw_on_q;
         bit_cnt_d = 4'd0;
         to_cnt_d  = '0;
         link_ok_d = 1'b1;
      end else begin
         if (shift_evt) begin
            shreg_d    = {shreg_q[6:0], 1'b1};
            frame_tp_d = (bit_cnt_q == 4'd7);
            if (bit_cnt_q != 4'd8) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               link_ok_d = 1'b0;
            end
         end
      end
   end

   // state registers; reset idles the line high with every switch OFF
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sht_sync_q <= '1;
         clk_sync_q <= '1;
         sw_sync_q  <= '1;
         clk_hist_q <= 1'b1;
         deb_cnt_q  <= '0;
         sw_on_q    <= '0;
         shreg_q    <= '1;
         dsw_dat_q  <= 1'b1;
         bit_cnt_q  <= 4'd0;
         frame_tp_q <= 1'b0;
         to_cnt_q   <= '0;
         link_ok_q  <= 1'b0;
      end else begin
         sht_sync_q <= sht_sync_d;
         clk_sync_q <= clk_sync_d;
         sw_sync_q  <= sw_sync_d;
         clk_hist_q <= clk_hist_d;
         deb_cnt_q  <= deb_cnt_d;
         sw_on_q    <= sw_on_d;
         shreg_q    <= shreg_d;
         dsw_dat_q  <= dsw_dat_d;
         bit_cnt_q  <= bit_cnt_d;
         frame_tp_q <= frame_tp_d;
         to_cnt_q   <= to_cnt_d;
         link_ok_q  <= link_ok_d;
      end
   end

   assign dsw.dsw_dat = dsw_dat_q;
   assign sw_on       = sw_on_q;
   assign frame_tp    = frame_tp_q;
   assign bit_cnt     = bit_cnt_q;
   assign link_ok     = link_ok_q;

endmodule

// File: tb/tb_dsw_ser.sv
// Testbench for dsw_ser: directed link scenarios plus random traffic against a frame-level reference model.
// Latency: model predicts every output per cycle from pin histories.
// Backpressure: n/a, the bench plays the reader.
module tb_dsw_ser;
   localparam int SYNC_STAGES    = 2;
   localparam int DEB_CYCLES     = 16;
   localparam int TIMEOUT_CYCLES = 1000;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] sw_n  = 8'hFF;
   logic [7:0] sw_on;
   logic       frame_tp;
   logic [3:0] bit_cnt;
   logic       link_ok;

   dsw_ser_if dif ();

   dsw_ser #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEB_CYCLES    (DEB_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_n    (sw_n),
      .dsw     (dif),
      .sw_on   (sw_on),
      .frame_tp(frame_tp),
      .bit_cnt (bit_cnt),
      .link_ok (link_ok)
   );

   always #20 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int tp_seen = 0;
   bit mon_en  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pin histories indexed by posedge count since reset release; earlier samples read as the reset level 1.
   bit         sht_h[$];
   bit         clk_h[$];
   logic [7:0] swn_h[$];
   logic [7:0] m_sw_on = 8'h00;
   bit         m_q[$];          // line levels still to be shifted out, front = current output bit
   int         m_cnt   = 0;
   bit         m_tp    = 1'b0;
   bit         m_link  = 1'b0;
   bit         m_have  = 1'b0;
   int         m_idle  = 0;
   bit         m_dat   = 1'b1;

   function automatic bit h_sht(int i);
      if (i < 0) return 1'b1;
      return sht_h[i];
   endfunction
   function automatic bit h_clk(int i);
      if (i < 0) return 1'b1;
      return clk_h[i];
   endfunction
   function automatic logic [7:0] h_swn(int i);
      if (i < 0) return 8'hFF;
      return swn_h[i];
   endfunction

   task automatic model_reset();
      sht_h.delete(); clk_h.delete(); swn_h.delete(); m_q.delete();
      m_sw_on = 8'h00; m_cnt = 0; m_tp = 1'b0; m_link = 1'b0;
      m_have = 1'b0; m_idle = 0; m_dat = 1'b1;
   endtask

   task automatic model_step();
      int         s;
      logic [7:0] nsw;
      logic [7:0] smp;
      bit         flip, sht_s, rise;
      sht_h.push_back(dif.dsw_sht);
      clk_h.push_back(dif.dsw_clk);
      swn_h.push_back(sw_n);
      s = sht_h.size() - 1 - SYNC_STAGES;   // sample the design acts on at this edge
      m_dat = (m_q.size() == 0) ? 1'b1 : m_q[0];
      // a switch flips once its last DEB_CYCLES samples all disagree with the accepted state
      nsw = m_sw_on;
      for (int b = 0; b < 8; b++) begin
         flip = 1'b1;
         for (int k = 0; k < DEB_CYCLES; k++) begin
            smp = h_swn(s - k);
            if (!smp[b] == m_sw_on[b]) flip = 1'b0;
         end
         if (flip) nsw[b] = ~m_sw_on[b];
      end
      sht_s = h_sht(s);
      rise  = h_clk(s) && !h_clk(s - 1);
      m_tp  = 1'b0;
      if (!sht_s) begin
         m_q.delete();
         for (int k = 7; k >= 0; k--) m_q.push_back(!m_sw_on[k]);
         m_cnt = 0; m_idle = 0; m_have = 1'b1;
      end else begin
         if (rise) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            m_tp = (m_cnt == 7);
            if (m_cnt < 8) m_cnt++;
         end
         if (m_idle < TIMEOUT_CYCLES) m_idle++;
      end
      m_link  = m_have && (m_idle < TIMEOUT_CYCLES);
      m_sw_on = nsw;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
   end

   // per-cycle comparison of every output against the model
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         chk("sw_on",    sw_on,       m_sw_on);
         chk("dsw_dat",  dif.dsw_dat, m_dat);
         chk("bit_cnt",  bit_cnt,     m_cnt);
         chk("frame_tp", frame_tp,    m_tp);
         chk("link_ok",  link_ok,     m_link);
         if (frame_tp) tp_seen++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic pulse();
      dif.dsw_clk = 1'b1; cyc(4);
      dif.dsw_clk = 1'b0; cyc(4);
   endtask
   task automatic load(input int n);
      dif.dsw_sht = 1'b0; cyc(n);
      dif.dsw_sht = 1'b1;
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] seq;
      logic [7:0] exp_on;
      int         tp0, k, hold;
      bit         glitch;
      dif.dsw_sht = 1'b1;
      dif.dsw_clk = 1'b0;
      #5 rst_n = 1'b0;
      #1;
      chk("rst_dat",    dif.dsw_dat, 1);
      chk("rst_sw_on",  sw_on,       0);
      chk("rst_bitcnt", bit_cnt,     0);
      chk("rst_tp",     frame_tp,    0);
      chk("rst_link",   link_ok,     0);
      cyc(3);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // bit order
      sw_n = 8'b0101_1100;
      cyc(SYNC_STAGES + DEB_CYCLES + 4);
      chk("deb_a3", sw_on, 8'hA3);
      load(2);
      cyc(SYNC_STAGES + 2);
      tp0 = tp_seen;
      seq = 8'h00;
      for (int i = 0; i < 8; i++) begin
         seq[7-i] = dif.dsw_dat;
         pulse();
      end
      chk("bit_order", seq, 8'h5C);
      cyc(4);
      chk("frame_bitcnt", bit_cnt, 8);
      chk("frame_tp_cnt", tp_seen - tp0, 1);

      // overshift
      for (int i = 0; i < 2; i++) begin
         chk("over_dat", dif.dsw_dat, 1);
         pulse();
      end
      cyc(2);
      chk("over_bitcnt", bit_cnt, 8);
      chk("over_tp_cnt", tp_seen - tp0, 1);

      // simultaneous load and shift edge
      exp_on = 8'hA3;
      dif.dsw_sht = 1'b0;
      dif.dsw_clk = 1'b1;
      cyc(2);
      dif.dsw_sht = 1'b1;
      cyc(4);
      chk("simul_bitcnt", bit_cnt, 0);
      chk("simul_dat", dif.dsw_dat, !exp_on[7]);
      dif.dsw_clk = 1'b0;
      cyc(4);

      // debounce of switch 1
      sw_n[0] = 1'b1;
      cyc(SYNC_STAGES + DEB_CYCLES + 4);
      chk("deb_off", sw_on[0], 0);
      glitch = 1'b0;
      for (int i = 0; i < 20; i++) begin
         sw_n[0] = ~sw_n[0];
         for (int j = 0; j < 5; j++) begin
            cyc(1);
            if (sw_on[0]) glitch = 1'b1;
         end
      end
      chk("bounce_hold", glitch, 0);
      sw_n[0] = 1'b0;
      k = 0;
      while (k < 100 && !sw_on[0]) begin
         cyc(1);
         k++;
      end
      chk("deb_latency", k, SYNC_STAGES + DEB_CYCLES);

      // timeout
      load(1);
      k = 0;
      while (k < 1500 && link_ok) begin
         cyc(1);
         k++;
      end
      chk("to_fall", k, TIMEOUT_CYCLES + SYNC_STAGES);
      dif.dsw_sht = 1'b0;
      k = 0;
      while (k < 20 && !link_ok) begin
         cyc(1);
         k++;
      end
      dif.dsw_sht = 1'b1;
      chk("to_restore", k, SYNC_STAGES + 1);
      cyc(4);

      // mid-frame reset
      sw_n = 8'h00;
      cyc(SYNC_STAGES + DEB_CYCLES + 4);
      chk("deb_ff", sw_on, 8'hFF);
      load(2);
      cyc(4);
      for (int i = 0; i < 3; i++) pulse();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dat",    dif.dsw_dat, 1);
      chk("mid_rst_bitcnt", bit_cnt,     0);
      chk("mid_rst_link",   link_ok,     0);
      cyc(2);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk("post_rst_dat", dif.dsw_dat, 1);
         pulse();
      end
      cyc(SYNC_STAGES + DEB_CYCLES + 4);
      chk("post_rst_ff", sw_on, 8'hFF);
      load(2);
      cyc(4);
      for (int i = 0; i < 8; i++) begin
         chk("ff_dat", dif.dsw_dat, 0);
         pulse();
      end

      // random traffic, every cycle checked against the model
      hold = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 29) == 0) sw_n = sw_n ^ 8'($urandom);
         if (dif.dsw_sht) begin
            if ($urandom_range(0, 49) == 0) dif.dsw_sht = 1'b0;
         end else if ($urandom_range(0, 1) == 0) begin
            dif.dsw_sht = 1'b1;
         end
         hold--;
         if (hold == 0) begin
            dif.dsw_clk = ~dif.dsw_clk;
            hold = int'($urandom_range(1, 6));
         end
         cyc(1);
      end
      cyc(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
